// File: rtl/fetch_queue.sv
// Instruction fetch stage: prefetches sequential {pc, ir} pairs into a small FIFO and flushes on redirect.
// Optional FETCH_QUEUE_BYPASS_EN: when the FIFO is empty, a response is presented at the outputs in the same cycle.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              imem_address,
    output logic                     imem_read,
    input  logic [31:0]              imem_rdata,
    input  logic                     imem_resp,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     deq,
    output logic                     valid,
    output logic [31:0]              pc,
    output logic [31:0]              ir,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [31:0]     fetch_pc_r, fetch_pc_s;
    logic [31:0]     req_addr_r, req_addr_s;
    logic [PW-1:0]   head_r, tail_r;
    logic [CW-1:0]   count_r, post_cnt_s;
    logic [31:0]     pc_mem [DEPTH];
    logic [31:0]     ir_mem [DEPTH];
    logic            resp_ok_s, byp_s, enq_s, pop_s;
    logic [31:0]     target_s;

    assign resp_ok_s = (state_r == REQ) && imem_resp && !redirect;
    assign target_s  = redirect_pc & 32'hFFFF_FFFC;

    // Datapath decisions: bypass consumption, enqueue, pop and resulting occupancy
    always_comb begin
        byp_s = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (resp_ok_s && (count_r == '0) && deq) begin
            byp_s = 1'b1;
        end else begin
            byp_s = 1'b0;
        end
`endif
        enq_s      = resp_ok_s && !byp_s;
        pop_s      = deq && !redirect && (count_r != '0);
        post_cnt_s = count_r + CW'(enq_s) - CW'(pop_s);
    end

    // Fetch FSM next-state and address bookkeeping
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        req_addr_s = req_addr_r;
        case (state_r)
            IDLE: begin
                if (!redirect && (count_r < FULL)) begin
                    req_addr_s = fetch_pc_r;
                    state_s    = REQ;
                end else begin
                    state_s    = IDLE;
                end
            end
            REQ: begin
                if (redirect) begin
                    // An outstanding request must still be drained before refetching.
                    state_s = imem_resp ? IDLE : DROP;
                end else if (imem_resp) begin
                    fetch_pc_s = req_addr_r + 32'd4;
                    if (post_cnt_s < FULL) begin
                        req_addr_s = req_addr_r + 32'd4;
                        state_s    = REQ;
                    end else begin
                        state_s    = IDLE;
                    end
                end else begin
                    state_s = REQ;
                end
            end
            DROP: begin
                if (imem_resp) begin
                    state_s = IDLE;
                end else begin
                    state_s = DROP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        if (redirect) begin
            fetch_pc_s = target_s;
        end else begin
            fetch_pc_s = fetch_pc_s;
        end
    end

    // Control state, FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            req_addr_r <= RESET_PC;
            head_r     <= '0;
            tail_r     <= '0;
            count_r    <= '0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            req_addr_r <= req_addr_s;
            if (redirect) begin
                head_r  <= '0;
                tail_r  <= '0;
                count_r <= '0;
            end else begin
                head_r  <= pop_s ? head_r + PTR_ONE : head_r;
                tail_r  <= enq_s ? tail_r + PTR_ONE : tail_r;
                count_r <= post_cnt_s;
            end
        end
    end

    // FIFO payload storage
    always_ff @(posedge clk) begin
        if (enq_s) begin
            pc_mem[tail_r] <= req_addr_r;
            ir_mem[tail_r] <= imem_rdata;
        end
    end

    assign imem_read    = (state_r != IDLE);
    assign imem_address = req_addr_r;
    assign count        = count_r;

    // Head-of-queue presentation
    always_comb begin
        if (count_r != '0) begin
            valid = 1'b1;
            pc    = pc_mem[head_r];
            ir    = ir_mem[head_r];
        end else begin
            valid = 1'b0;
            pc    = 32'h0000_0000;
            ir    = NOP;
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        if (resp_ok_s && (count_r == '0)) begin
            valid = 1'b1;
            pc    = req_addr_r;
            ir    = imem_rdata;
        end else begin
            valid = valid;
        end
`endif
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven saturation vectors, scoreboarded consumer, redirect corner cases.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_resp = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        deq = 1'b0;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h4000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq(deq), .valid(valid), .pc(pc), .ir(ir), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] ir; } ent_t;
    typedef struct {
        logic        deq;
        logic        read;
        logic [31:0] addr;
        logic [2:0]  cnt;
        logic        vld;
        logic [31:0] hpc;
    } vec_t;

    ent_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          lat = 0;
    int          wait_cnt = 0;
    int          pop_cnt = 0;
    bit          mem_en = 1'b1;
    bit          keep = 1'b1;
    logic [31:0] nxt_fetch = 32'h4000_0000;
    logic        pre_valid;
    logic [31:0] pre_ir;
    logic [31:0] pre_pc;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_read"},  {31'h0, imem_read}, 32'h0);
        chk({tag, "_addr"},  imem_address, 32'h4000_0000);
        chk({tag, "_count"}, {29'h0, count}, 32'h0);
        chk({tag, "_valid"}, {31'h0, valid}, 32'h0);
        chk({tag, "_pc"},    pc, 32'h0);
        chk({tag, "_ir"},    ir, 32'h0000_0013);
    endtask

    // One clock of memory model + consumer; leaves time at edge+2
    task automatic cycle();
        bit   r;
        bit   rd;
        ent_t e;
        rd = imem_read;
        r  = mem_en && rd && (wait_cnt >= lat);
        imem_resp  = r;
        imem_rdata = r ? word_of(imem_address) : 32'h0;
        if (r && keep) begin
            chk("fetch_addr", imem_address, nxt_fetch);
            sb.push_back('{nxt_fetch, word_of(nxt_fetch)});
            nxt_fetch += 32'd4;
        end
        #1;
        pre_valid = valid;
        pre_ir    = ir;
        pre_pc    = pc;
        if (deq && !redirect && valid) begin
            pop_cnt++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_underrun: got pc %h, expected no entry", pc);
            end else begin
                e = sb.pop_front();
                chk("pop_pc", pc, e.pc);
                chk("pop_ir", ir, e.ir);
            end
        end
        if (redirect) sb.delete();
        @(posedge clk);
        wait_cnt = r ? 0 : (rd ? wait_cnt + 1 : 0);
        #1;
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        deq = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem_resp = 1'b0; imem_rdata = 32'h0;
        mem_en = 1'b1; keep = 1'b1; lat = 0; wait_cnt = 0; pop_cnt = 0;
        nxt_fetch = 32'h4000_0000;
        sb.delete();
        @(posedge clk); #1; @(posedge clk); #2;
        rst = 1'b0;
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b0, 1'b1, 32'h4000_0000, 3'd0, 1'b0, 32'h0000_0000};
        tbl[1] = '{1'b0, 1'b1, 32'h4000_0004, 3'd1, 1'b1, 32'h4000_0000};
        tbl[2] = '{1'b0, 1'b1, 32'h4000_0008, 3'd2, 1'b1, 32'h4000_0000};
        tbl[3] = '{1'b0, 1'b1, 32'h4000_000C, 3'd3, 1'b1, 32'h4000_0000};
        tbl[4] = '{1'b0, 1'b0, 32'h4000_000C, 3'd4, 1'b1, 32'h4000_0000};
        tbl[5] = '{1'b0, 1'b0, 32'h4000_000C, 3'd4, 1'b1, 32'h4000_0000};
        tbl[6] = '{1'b1, 1'b0, 32'h4000_000C, 3'd3, 1'b1, 32'h4000_0004};
        tbl[7] = '{1'b0, 1'b1, 32'h4000_0010, 3'd3, 1'b1, 32'h4000_0004};
        tbl[8] = '{1'b0, 1'b0, 32'h4000_0010, 3'd4, 1'b1, 32'h4000_0004};
        tbl[9] = '{1'b0, 1'b0, 32'h4000_0010, 3'd4, 1'b1, 32'h4000_0004};

        // Reset values, then streaming with deq held high
        do_reset();
        chk_reset_outs("rst");
        deq = 1'b1;
        for (int i = 0; i < 12; i++) cycle();
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("tp_pops", pop_cnt, 32'd11);
`else
        chk("tp_pops", pop_cnt, 32'd10);
`endif
        rst = 1'b1;
        #1;
        chk_reset_outs("midrst");

        // Saturation with deq low, then a single deq
        do_reset();
        for (int i = 0; i < 10; i++) begin
            deq = tbl[i].deq;
            cycle();
            chk($sformatf("sat%0d_read", i),  {31'h0, imem_read}, {31'h0, tbl[i].read});
            chk($sformatf("sat%0d_addr", i),  imem_address, tbl[i].addr);
            chk($sformatf("sat%0d_count", i), {29'h0, count}, {29'h0, tbl[i].cnt});
            chk($sformatf("sat%0d_valid", i), {31'h0, valid}, {31'h0, tbl[i].vld});
            chk($sformatf("sat%0d_pc", i),    pc, tbl[i].hpc);
        end
        deq = 1'b0;

        // Redirect with an outstanding request -> DROP
        do_reset();
        cycle(); cycle(); cycle();
        chk("drop_pre_addr", imem_address, 32'h4000_0008);
        lat = 3; keep = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h4000_1002;
        cycle();
        redirect = 1'b0;
        chk("drop_read", {31'h0, imem_read}, 32'h1);
        chk("drop_addr0", imem_address, 32'h4000_0008);
        chk("drop_valid", {31'h0, valid}, 32'h0);
        chk("drop_count", {29'h0, count}, 32'h0);
        cycle();
        chk("drop_addr1", imem_address, 32'h4000_0008);
        cycle();
        chk("drop_addr2", imem_address, 32'h4000_0008);
        cycle();
        chk("drop_done_read", {31'h0, imem_read}, 32'h0);
        chk("drop_done_valid", {31'h0, valid}, 32'h0);
        lat = 0; keep = 1'b1; nxt_fetch = 32'h4000_1000;
        cycle();
        chk("drop_refetch", imem_address, 32'h4000_1000);
        chk("drop_refetch_valid", {31'h0, valid}, 32'h0);
        cycle();
        chk("drop_new_valid", {31'h0, valid}, 32'h1);
        chk("drop_new_pc", pc, 32'h4000_1000);
        deq = 1'b1;
        cycle();
        deq = 1'b0;

        // Redirect and response in the same cycle
        do_reset();
        cycle();
        keep = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h4000_2000;
        cycle();
        redirect = 1'b0;
        chk("rr_read", {31'h0, imem_read}, 32'h0);
        chk("rr_count", {29'h0, count}, 32'h0);
        chk("rr_valid", {31'h0, valid}, 32'h0);
        keep = 1'b1; nxt_fetch = 32'h4000_2000;
        cycle();
        chk("rr_addr", imem_address, 32'h4000_2000);
        cycle();
        chk("rr_count1", {29'h0, count}, 32'h1);
        chk("rr_pc", pc, 32'h4000_2000);

        // deq on empty, then redirect+deq on a non-empty queue
        do_reset();
        mem_en = 1'b0;
        cycle();
        deq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("empty_deq_count", {29'h0, count}, 32'h0);
            chk("empty_deq_valid", {31'h0, valid}, 32'h0);
        end
        deq = 1'b0; mem_en = 1'b1;
        cycle(); cycle();
        chk("fill2_count", {29'h0, count}, 32'h2);
        mem_en = 1'b0;
        redirect = 1'b1; deq = 1'b1; redirect_pc = 32'h4000_3000;
        cycle();
        redirect = 1'b0; deq = 1'b0;
        chk("rd_count", {29'h0, count}, 32'h0);
        chk("rd_valid", {31'h0, valid}, 32'h0);
        chk("rd_addr", imem_address, 32'h4000_0008);
        mem_en = 1'b1; keep = 1'b0;
        cycle();
        chk("rd_idle", {31'h0, imem_read}, 32'h0);
        keep = 1'b1; nxt_fetch = 32'h4000_3000;
        cycle();
        chk("rd_target", imem_address, 32'h4000_3000);
        cycle(); cycle();
        deq = 1'b1;
        cycle(); cycle();
        deq = 1'b0;
        chk("rd_post_count", {29'h0, count}, 32'h2);
        chk("rd_post_pc", pc, 32'h4000_3008);

        // Response-cycle visibility with an empty queue and deq high
        do_reset();
        deq = 1'b1;
        cycle();
        cycle();
        deq = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_valid", {31'h0, pre_valid}, 32'h1);
        chk("byp_ir", pre_ir, word_of(32'h4000_0000));
        chk("byp_pc", pre_pc, 32'h4000_0000);
        chk("byp_count", {29'h0, count}, 32'h0);
`else
        chk("nobyp_valid", {31'h0, pre_valid}, 32'h0);
        chk("nobyp_ir", pre_ir, 32'h0000_0013);
        chk("nobyp_count", {29'h0, count}, 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
